wl_dec_seq: RTL and testbench

//  Parametrised, registered successor to the combinational 3-to-8 active-low wordline decoder.

---
 rtl/wl_dec_seq.sv | 129 ++++++++++++
 tb/tb_wl_dec_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/wl_dec_seq.sv
// Registered wordline sequencer: precharge, then a timed one-hot active-low wordline pulse, then recovery.
// All array-facing outputs are flops; req_ready is high only in IDLE, and req_valid while busy is ignored.
module wl_dec_seq #(
    parameter int ADDR_W    = 3,
    parameter int PRE_CYC   = 1,
    parameter int PULSE_CYC = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic                   req_we,
    output logic [(2**ADDR_W)-1:0] wl_n,
    output logic                   pre_n,
    output logic                   we_o,
    output logic                   busy,
    output logic                   done
);
    localparam int NWL = 2 ** ADDR_W;
    localparam logic [3:0] PRE_LD = (PRE_CYC > 0) ? 4'(PRE_CYC - 1) : 4'd0;
    localparam logic [3:0] PUL_LD = 4'(PULSE_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_WL   = 2'd2,
        S_REC  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              r_we;
    logic              w_we_nxt;
    logic              w_accept;
    logic [NWL-1:0]    w_onehot;
    logic [NWL-1:0]    r_wl_n;
    logic              r_pre_n;
    logic              r_we_o;
    logic              r_busy;
    logic              r_done;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (PRE_CYC > 0) begin
                        w_state_nxt = S_PRE;
                        w_cnt_nxt   = PRE_LD;
                    end else begin
                        w_state_nxt = S_WL;
                        w_cnt_nxt   = PUL_LD;
                    end
                end
            end
            S_PRE: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_WL;
                    w_cnt_nxt   = PUL_LD;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_WL: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_REC;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_REC: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so each phase's levels appear in the same cycle as the phase.
    always_comb begin
        w_addr_nxt = w_accept ? req_addr : r_addr;
        w_we_nxt   = w_accept ? req_we   : r_we;
        w_onehot   = '0;
        w_onehot[w_addr_nxt] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wl_n  <= '1;
            r_pre_n <= 1'b1;
            r_we_o  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
            r_we    <= w_we_nxt;
            r_wl_n  <= (w_state_nxt == S_WL) ? ~w_onehot : '1;
            r_pre_n <= (w_state_nxt != S_PRE);
            r_we_o  <= (w_state_nxt != S_IDLE) ? w_we_nxt : 1'b0;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (w_state_nxt == S_REC);
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign wl_n      = r_wl_n;
    assign pre_n     = r_pre_n;
    assign we_o      = r_we_o;
    assign busy      = r_busy;
    assign done      = r_done;
endmodule

// File: tb/tb_wl_dec_seq.sv
// Directed bench for wl_dec_seq: default build (3/1/2) plus a 4/0/1 build sharing clock and reset.
module tb_wl_dec_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_addr = '0;
    logic        req_we = 1'b0;
    logic [7:0]  wl_n;
    logic        pre_n, we_o, busy, done;

    logic        req_valid6 = 1'b0;
    logic        req_ready6;
    logic [3:0]  req_addr6 = '0;
    logic        req_we6 = 1'b0;
    logic [15:0] wl_n6;
    logic        pre_n6, we_o6, busy6, done6;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wl_dec_seq u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_we(req_we), .wl_n(wl_n), .pre_n(pre_n),
        .we_o(we_o), .busy(busy), .done(done)
    );

    wl_dec_seq #(.ADDR_W(4), .PRE_CYC(0), .PULSE_CYC(1)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid6), .req_ready(req_ready6),
        .req_addr(req_addr6), .req_we(req_we6), .wl_n(wl_n6), .pre_n(pre_n6),
        .we_o(we_o6), .busy(busy6), .done(done6)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_wl;
        int         hits;

        // T1: reset with clock running
        repeat (3) cyc();
        check("t1_wl_n", 32'(wl_n), 32'hFF);
        check("t1_pre_n", 32'(pre_n), 1);
        check("t1_ready", 32'(req_ready), 1);
        check("t1_busy", 32'(busy), 0);
        check("t1_done", 32'(done), 0);
        check("t1_we_o", 32'(we_o), 0);
        check("t1_wl_n6", 32'(wl_n6), 32'hFFFF);
        rst_n = 1'b1;
        cyc();

        // T2: addr=5 we=1
        req_valid = 1'b1; req_addr = 3'd5; req_we = 1'b1;
        check("t2_ready0", 32'(req_ready), 1);
        cyc();
        req_valid = 1'b0; req_we = 1'b0;
        check("t2_c1_pre_n", 32'(pre_n), 0);
        check("t2_c1_wl_n", 32'(wl_n), 32'hFF);
        check("t2_c1_busy", 32'(busy), 1);
        check("t2_c1_ready", 32'(req_ready), 0);
        cyc();
        check("t2_c2_wl_n", 32'(wl_n), 32'hDF);
        check("t2_c2_we_o", 32'(we_o), 1);
        check("t2_c2_pre_n", 32'(pre_n), 1);
        cyc();
        check("t2_c3_wl_n", 32'(wl_n), 32'hDF);
        check("t2_c3_done", 32'(done), 0);
        cyc();
        check("t2_c4_wl_n", 32'(wl_n), 32'hFF);
        check("t2_c4_done", 32'(done), 1);
        check("t2_c4_ready", 32'(req_ready), 0);
        cyc();
        check("t2_c5_ready", 32'(req_ready), 1);
        check("t2_c5_done", 32'(done), 0);
        check("t2_c5_busy", 32'(busy), 0);
        check("t2_c5_we_o", 32'(we_o), 0);

        // T3: held valid, address changed during PRE
        req_valid = 1'b1; req_addr = 3'd2; req_we = 1'b0;
        cyc();
        req_addr = 3'd6;
        check("t3_c1_pre_n", 32'(pre_n), 0);
        check("t3_c1_ready", 32'(req_ready), 0);
        cyc();
        check("t3_c2_wl_n", 32'(wl_n), 32'hFB);
        cyc();
        check("t3_c3_wl_n", 32'(wl_n), 32'hFB);
        cyc();
        check("t3_c4_done", 32'(done), 1);
        check("t3_c4_ready", 32'(req_ready), 0);
        cyc();
        check("t3_c5_ready", 32'(req_ready), 1);
        cyc();
        req_valid = 1'b0;
        check("t3_c6_pre_n", 32'(pre_n), 0);
        cyc();
        check("t3_c7_wl_n", 32'(wl_n), 32'hBF);
        cyc();
        check("t3_c8_wl_n", 32'(wl_n), 32'hBF);
        cyc();
        check("t3_c9_done", 32'(done), 1);
        cyc();
        check("t3_c10_ready", 32'(req_ready), 1);

        // T4: reset during 2nd WL cycle of addr=7
        req_valid = 1'b1; req_addr = 3'd7; req_we = 1'b1;
        cyc();
        req_valid = 1'b0;
        cyc();
        cyc();
        check("t4_wl2_wl_n", 32'(wl_n), 32'h7F);
        #1 rst_n = 1'b0;
        #1;
        check("t4_async_wl_n", 32'(wl_n), 32'hFF);
        check("t4_async_busy", 32'(busy), 0);
        check("t4_async_we_o", 32'(we_o), 0);
        check("t4_async_ready", 32'(req_ready), 1);
        repeat (2) begin
            cyc();
            check("t4_rst_done", 32'(done), 0);
        end
        rst_n = 1'b1;
        repeat (3) begin
            cyc();
            check("t4_post_done", 32'(done), 0);
            check("t4_post_ready", 32'(req_ready), 1);
        end

        // T5: back-to-back sweep of all wordlines
        for (int a = 0; a < 8; a++) begin
            req_valid = 1'b1;
            req_addr  = 3'(a);
            check($sformatf("t5_ready_a%0d", a), 32'(req_ready), 1);
            exp_wl = ~(8'd1 << a);
            hits = 0;
            for (int i = 1; i <= 5; i++) begin
                cyc();
                if (wl_n == exp_wl) hits++;
                check("t5_popcount_le1", 32'($countones(~wl_n) <= 1), 1);
                check("t5_pre_wl_excl", 32'(!(pre_n == 1'b0 && wl_n != 8'hFF)), 1);
            end
            check($sformatf("t5_hits_a%0d", a), 32'(hits), 2);
        end
        req_valid = 1'b0;
        cyc();
        check("t5_end_ready", 32'(req_ready), 1);

        // T6: ADDR_W=4, PRE_CYC=0, PULSE_CYC=1, addr=15
        req_valid6 = 1'b1; req_addr6 = 4'd15; req_we6 = 1'b1;
        check("t6_ready0", 32'(req_ready6), 1);
        cyc();
        req_valid6 = 1'b0;
        check("t6_c1_wl_n", 32'(wl_n6), 32'h7FFF);
        check("t6_c1_pre_n", 32'(pre_n6), 1);
        check("t6_c1_we_o", 32'(we_o6), 1);
        cyc();
        check("t6_c2_done", 32'(done6), 1);
        check("t6_c2_wl_n", 32'(wl_n6), 32'hFFFF);
        cyc();
        check("t6_c3_ready", 32'(req_ready6), 1);
        check("t6_c3_done", 32'(done6), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
